// File: rtl/hc595_rx_decoder_pkg.sv
// Shared constants for the 74HC595 link receiver: field positions, digit codes and
// the active-low 7-segment pattern table.
package hc595_rx_decoder_pkg;

   localparam int unsigned FLD_DP      = 13;
   localparam int unsigned FLD_PAT_MSB = 12;
   localparam int unsigned FLD_PAT_LSB = 6;
   localparam int unsigned FLD_SEL_MSB = 5;
   localparam int unsigned CODE_W      = 5;
   localparam int unsigned CNT_W       = 5;

   localparam logic [4:0] CODE_BLANK = 5'd16;
   localparam logic [4:0] CODE_MINUS = 5'd17;
   localparam logic [4:0] CODE_UNK   = 5'd31;

   localparam logic [6:0] PAT_BLANK = 7'h7F;
   localparam logic [6:0] PAT_MINUS = 7'h3F;

   // {g,f,e,d,c,b,a}, active-low, indexed by hex value
   localparam logic [6:0] SEG_HEX_PAT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {
      WORD_OK,
      WORD_BAD_LEN,
      WORD_BAD_SEL,
      WORD_BAD_PAT
   } word_stat_e;

endpackage

// File: rtl/hc595_rx_decoder_if.sv
// Link pins plus decoded status of the 74HC595 receiver; master drives the link,
// slave is the decoder.
interface hc595_rx_decoder_if #(
   parameter int unsigned DIG_N = 6
);
   logic               shcp;
   logic               stcp;
   logic               ds;
   logic               oe;
   logic [DIG_N*5-1:0] digit_code;
   logic [DIG_N-1:0]   digit_dp;
   logic               word_valid;
   logic               frame_done;
   logic               disp_on;
   logic [7:0]         err_cnt;

   modport master (
      output shcp, stcp, ds, oe,
      input  digit_code, digit_dp, word_valid, frame_done, disp_on, err_cnt
   );

   modport slave (
      input  shcp, stcp, ds, oe,
      output digit_code, digit_dp, word_valid, frame_done, disp_on, err_cnt
   );
endinterface

// File: rtl/hc595_rx_decoder_seg7_pattern_decode.sv
// Combinational 7-segment pattern to digit-code decoder: 0..15 hex, blank, minus,
// or the unknown code for anything else.
module seg7_pattern_decode
   import hc595_rx_decoder_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [4:0] code
);

   always_comb begin
      code = CODE_UNK;
      if (pattern == PAT_BLANK) begin
         code = CODE_BLANK;
      end else if (pattern == PAT_MINUS) begin
         code = CODE_MINUS;
      end else begin
         for (int unsigned i = 0; i < 16; i++) begin
            if (pattern == SEG_HEX_PAT[i]) code = 5'(i);
         end
      end
   end

endmodule

// File: rtl/hc595_rx_decoder.sv
// Receive side of the 74HC595 digit-display link: resynchronises the link pins,
// rebuilds each latched word and decodes it into per-digit codes and status.
module hc595_rx_decoder
   import hc595_rx_decoder_pkg::*;
#(
   parameter int unsigned SHIFT_W = 14,
   parameter int unsigned DIG_N   = 6,
   parameter int unsigned SYNC_FF = 2
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   hc595_rx_decoder_if.slave link
);

   logic [SYNC_FF-1:0][3:0]  sync_q, sync_d;
   logic [3:0]               pin_s;
   logic [1:0]               prev_q, prev_d;
   logic                     shcp_rise, stcp_rise;

   logic [SHIFT_W-1:0]       sh_q, sh_d;
   logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
   logic [SHIFT_W-1:0]       word_q, word_d;
   logic                     latch_q, latch_d;
   logic                     len_ok_q, len_ok_d;

   logic [DIG_N*CODE_W-1:0]  digit_code_q, digit_code_d;
   logic [DIG_N-1:0]         digit_dp_q, digit_dp_d;
   logic [DIG_N-1:0]         seen_q, seen_d, seen_set;
   logic                     word_valid_q, word_valid_d;
   logic                     frame_done_q, frame_done_d;
   logic                     disp_on_q, disp_on_d;
   logic [7:0]               err_cnt_q, err_cnt_d;

   logic [DIG_N-1:0]         sel;
   logic                     sel_onehot;
   logic [4:0]               pat_code;
   word_stat_e               word_stat;

   // pin order in the synchroniser: {oe, ds, stcp, shcp}
   assign pin_s     = sync_q[SYNC_FF-1];
   assign shcp_rise = pin_s[0] & ~prev_q[0];
   assign stcp_rise = pin_s[1] & ~prev_q[1];

   always_comb begin
      sync_d = {sync_q[SYNC_FF-2:0], {link.oe, link.ds, link.stcp, link.shcp}};
      prev_d = pin_s[1:0];
   end

   // A coincident latch captures the pre-shift register, so the new bit starts the next word.
   always_comb begin
      sh_d      = sh_q;
      bit_cnt_d = bit_cnt_q;
      word_d    = word_q;
      latch_d   = 1'b0;
      len_ok_d  = len_ok_q;
      if (stcp_rise) begin
         word_d    = sh_q;
         latch_d   = 1'b1;
         len_ok_d  = (bit_cnt_q == CNT_W'(SHIFT_W));
         bit_cnt_d = '0;
      end
      if (shcp_rise) begin
         sh_d = {sh_q[SHIFT_W-2:0], pin_s[2]};
         if (stcp_rise) begin
            bit_cnt_d = CNT_W'(1);
         end else if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
      end
   end

   seg7_pattern_decode u_pat_dec (
      .pattern (word_q[FLD_PAT_MSB:FLD_PAT_LSB]),
      .code    (pat_code)
   );

   assign sel        = word_q[FLD_SEL_MSB:0];
   assign sel_onehot = (sel != '0) &&
                       ((sel & (sel - {{(DIG_N-1){1'b0}}, 1'b1})) == '0);

   always_comb begin
      if (!len_ok_q) begin
         word_stat = WORD_BAD_LEN;
      end else if (!sel_onehot) begin
         word_stat = WORD_BAD_SEL;
      end else if (pat_code == CODE_UNK) begin
         word_stat = WORD_BAD_PAT;
      end else begin
         word_stat = WORD_OK;
      end
   end

   // Unknown patterns are still displayed; they only add to the error count.
   always_comb begin
      digit_code_d = digit_code_q;
      digit_dp_d   = digit_dp_q;
      seen_d       = seen_q;
      seen_set     = seen_q | sel;
      word_valid_d = latch_q;
      frame_done_d = 1'b0;
      err_cnt_d    = err_cnt_q;
      disp_on_d    = ~pin_s[3];
      if (latch_q) begin
         if (word_stat == WORD_OK || word_stat == WORD_BAD_PAT) begin
            for (int unsigned i = 0; i < DIG_N; i++) begin
               if (sel[i]) begin
                  digit_code_d[CODE_W*i +: CODE_W] = pat_code;
                  digit_dp_d[i]                    = ~word_q[FLD_DP];
               end
            end
            if (&seen_set) begin
               frame_done_d = 1'b1;
               seen_d       = '0;
            end else begin
               seen_d = seen_set;
            end
         end
         if (word_stat != WORD_OK && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync_q       <= '0;
         prev_q       <= '0;
         sh_q         <= '0;
         bit_cnt_q    <= '0;
         word_q       <= '0;
         latch_q      <= 1'b0;
         len_ok_q     <= 1'b0;
         digit_code_q <= {DIG_N{CODE_BLANK}};
         digit_dp_q   <= '0;
         seen_q       <= '0;
         word_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         disp_on_q    <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         sync_q       <= sync_d;
         prev_q       <= prev_d;
         sh_q         <= sh_d;
         bit_cnt_q    <= bit_cnt_d;
         word_q       <= word_d;
         latch_q      <= latch_d;
         len_ok_q     <= len_ok_d;
         digit_code_q <= digit_code_d;
         digit_dp_q   <= digit_dp_d;
         seen_q       <= seen_d;
         word_valid_q <= word_valid_d;
         frame_done_q <= frame_done_d;
         disp_on_q    <= disp_on_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign link.digit_code = digit_code_q;
   assign link.digit_dp   = digit_dp_q;
   assign link.word_valid = word_valid_q;
   assign link.frame_done = frame_done_q;
   assign link.disp_on    = disp_on_q;
   assign link.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_hc595_rx_decoder.sv
// Bench for hc595_rx_decoder: drives the serial link bit by bit and compares every
// decoded word against a word-level model of the display protocol.
module tb_hc595_rx_decoder;

   localparam int SYNC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   hc595_rx_decoder_if #(.DIG_N(6)) link ();

   hc595_rx_decoder #(.SHIFT_W(14), .DIG_N(6), .SYNC_FF(SYNC)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .link    (link)
   );

   int tests = 0;
   int fails = 0;

   // model state
   int exp_code [6];
   bit exp_dp   [6];
   bit seen     [6];
   int exp_err;
   bit exp_disp;
   bit bits [$];
   int fd_count;

   localparam logic [6:0] MPAT [18] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
      7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h7F, 7'h3F
   };

   typedef struct {
      logic [7:0] seg;
      logic [5:0] sel;
      int         code;
      int         dp;
   } vec_t;
   vec_t vt [20];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int model_decode(input logic [6:0] p);
      for (int i = 0; i < 18; i++) if (p == MPAT[i]) return i;
      return 31;
   endfunction

   function automatic logic [29:0] exp_code_vec();
      logic [29:0] v;
      v = '0;
      for (int i = 0; i < 6; i++) v[5*i +: 5] = exp_code[i][4:0];
      return v;
   endfunction

   function automatic logic [5:0] exp_dp_vec();
      logic [5:0] v;
      for (int i = 0; i < 6; i++) v[i] = exp_dp[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 6; i++) begin
         exp_code[i] = 16;
         exp_dp[i]   = 1'b0;
         seen[i]     = 1'b0;
      end
      exp_err = 0;
      bits.delete();
   endtask

   task automatic model_latch(output bit fd);
      int len;
      int ones;
      int idx;
      int code;
      bit ok;
      bit all;
      logic [13:0] w;
      len  = bits.size();
      w    = '0;
      ones = 0;
      idx  = 0;
      fd   = 1'b0;
      if (len == 14) for (int i = 0; i < 14; i++) w[13-i] = bits[i];
      for (int i = 0; i < 6; i++) if (w[i]) begin ones++; idx = i; end
      ok   = (len == 14) && (ones == 1);
      code = model_decode(w[12:6]);
      if (ok) begin
         exp_code[idx] = code;
         exp_dp[idx]   = ~w[13];
         seen[idx]     = 1'b1;
         all = 1'b1;
         for (int i = 0; i < 6; i++) all &= seen[i];
         if (all) begin
            fd = 1'b1;
            for (int i = 0; i < 6; i++) seen[i] = 1'b0;
         end
      end
      if ((!ok || code == 31) && exp_err < 255) exp_err++;
      bits.delete();
   endtask

   task automatic send_bit(input bit b);
      @(negedge clk);
      link.ds = b;
      repeat (2) @(negedge clk);
      link.shcp = 1'b1;
      repeat (3) @(negedge clk);
      link.shcp = 1'b0;
      bits.push_back(b);
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      logic [15:0] t;
      t = v;
      for (int i = n - 1; i >= 0; i--) send_bit(t[i]);
   endtask

   // with_shift raises shcp together with stcp, carrying bit nb into the next word
   task automatic do_latch(input bit with_shift, input bit nb);
      bit fd;
      int lat;
      repeat (2) @(negedge clk);
      if (with_shift) begin
         link.ds = nb;
         repeat (2) @(negedge clk);
         link.shcp = 1'b1;
      end
      link.stcp = 1'b1;
      model_latch(fd);
      if (with_shift) bits.push_back(nb);
      lat = 0;
      while (lat < 12 && !link.word_valid) begin
         @(negedge clk);
         lat++;
         if (lat == 3) begin
            link.stcp = 1'b0;
            link.shcp = 1'b0;
         end
      end
      link.stcp = 1'b0;
      link.shcp = 1'b0;
      check("latency", 64'(lat), 64'(SYNC + 2));
      check("frame_done", link.frame_done, fd);
      fd_count += int'(link.frame_done);
      check("err_cnt", link.err_cnt, exp_err[7:0]);
      check("digit_code", link.digit_code, exp_code_vec());
      check("digit_dp", link.digit_dp, exp_dp_vec());
      check("disp_on", link.disp_on, exp_disp);
      @(negedge clk);
      check("wv_one_pulse", link.word_valid, 1'b0);
      check("fd_one_pulse", link.frame_done, 1'b0);
   endtask

   task automatic send_word(input logic [13:0] w);
      send_bits({2'b00, w}, 14);
      do_latch(1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs();
      check("rst_code", link.digit_code, {6{5'd16}});
      check("rst_dp", link.digit_dp, 6'd0);
      check("rst_wv", link.word_valid, 1'b0);
      check("rst_fd", link.frame_done, 1'b0);
      check("rst_err", link.err_cnt, 8'd0);
      check("rst_disp", link.disp_on, 1'b0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      model_reset();
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #4ms;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1);
   end

   initial begin
      logic [29:0] cv;
      logic [13:0] w1, w2;
      logic [15:0] rv;
      logic [7:0]  seg;
      logic [5:0]  sel;
      int          n, idx;

      vt[0]  = '{8'hC0, 6'b000001, 0, 0};   vt[1]  = '{8'h79, 6'b000010, 1, 1};
      vt[2]  = '{8'hA4, 6'b000100, 2, 0};   vt[3]  = '{8'h30, 6'b001000, 3, 1};
      vt[4]  = '{8'h99, 6'b010000, 4, 0};   vt[5]  = '{8'h12, 6'b100000, 5, 1};
      vt[6]  = '{8'h82, 6'b000001, 6, 0};   vt[7]  = '{8'hF8, 6'b000010, 7, 0};
      vt[8]  = '{8'h00, 6'b000100, 8, 1};   vt[9]  = '{8'h90, 6'b001000, 9, 0};
      vt[10] = '{8'h88, 6'b010000, 10, 0};  vt[11] = '{8'h83, 6'b100000, 11, 0};
      vt[12] = '{8'hC6, 6'b000001, 12, 0};  vt[13] = '{8'hA1, 6'b000010, 13, 0};
      vt[14] = '{8'h86, 6'b000100, 14, 0};  vt[15] = '{8'h8E, 6'b001000, 15, 0};
      vt[16] = '{8'hFF, 6'b010000, 16, 0};  vt[17] = '{8'hBF, 6'b100000, 17, 0};
      vt[18] = '{8'h7E, 6'b000001, 31, 1};  vt[19] = '{8'hC1, 6'b000010, 31, 0};

      link.shcp = 1'b0;
      link.stcp = 1'b0;
      link.ds   = 1'b0;
      link.oe   = 1'b0;
      exp_disp  = 1'b1;
      fd_count  = 0;
      model_reset();

      apply_reset();
      check("disp_on_after_rst", link.disp_on, 1'b1);

      // "0" on digit 0, decimal point off
      send_word({8'hC0, 6'b000001});
      check("d0_code", link.digit_code[4:0], 5'd0);
      check("d0_dp", link.digit_dp[0], 1'b0);

      send_word({8'h24, 6'b100000});
      check("d5_code_2", link.digit_code[29:25], 5'd2);
      send_word({8'h7F, 6'b100000});
      check("d5_code_blank", link.digit_code[29:25], 5'd16);
      check("d5_dp_on", link.digit_dp[5], 1'b1);
      check("d1to4_blank", link.digit_code[24:5], {4{5'd16}});

      apply_reset();
      fd_count = 0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 6; i++) begin
            sel = 6'b000001 << i;
            send_word({1'b1, MPAT[i], sel});
            if (i == 4) check("no_frame_before_6th", 64'(fd_count), 64'(k));
         end
         check("frame_count", 64'(fd_count), 64'(k + 1));
      end

      check("err_zero", link.err_cnt, 8'd0);
      cv = link.digit_code;
      send_bits(16'h1ABC, 13);
      do_latch(1'b0, 1'b0);
      check("err_len13", link.err_cnt, 8'd1);
      check("len13_no_change", link.digit_code, cv);
      send_word({8'hC0, 6'b000011});
      check("err_bad_sel", link.err_cnt, 8'd2);
      check("bad_sel_no_change", link.digit_code, cv);

      // latch coincides with the first bit of the next word
      w1 = {8'hF8, 6'b000100};
      w2 = {8'h99, 6'b001000};
      send_bits({2'b00, w1}, 14);
      do_latch(1'b1, w2[13]);
      check("simul_d2", link.digit_code[14:10], 5'd7);
      send_bits({3'b000, w2[12:0]}, 13);
      do_latch(1'b0, 1'b0);
      check("simul_next_d3", link.digit_code[19:15], 5'd4);
      check("simul_err", link.err_cnt, 8'd2);

      for (int t = 0; t < 20; t++) begin
         send_word({vt[t].seg, vt[t].sel});
         idx = 0;
         for (int i = 0; i < 6; i++) if (vt[t].sel[i]) idx = i;
         cv = link.digit_code;
         check($sformatf("vec%0d_code", t), 64'(cv[5*idx +: 5]), 64'(vt[t].code));
         check($sformatf("vec%0d_dp", t), 64'(link.digit_dp[idx]), 64'(vt[t].dp));
      end

      for (int r = 0; r < 60; r++) begin
         if ($urandom_range(0, 9) < 7) sel = 6'b000001 << $urandom_range(0, 5);
         else sel = 6'($urandom);
         if ($urandom_range(0, 9) < 7) seg = {1'($urandom), MPAT[$urandom_range(0, 17)]};
         else seg = 8'($urandom);
         n  = ($urandom_range(0, 9) < 8) ? 14 : int'($urandom_range(12, 16));
         rv = {2'($urandom), seg, sel};
         if (n < 14) rv = rv >> (14 - n);
         send_bits(rv, n);
         do_latch(1'b0, 1'b0);
      end

      for (int r = 0; r < 260; r++) do_latch(1'b0, 1'b0);
      check("err_saturated", link.err_cnt, 8'd255);

      send_bits(16'h0055, 7);
      apply_reset();
      send_word({8'h21, 6'b010000});
      check("post_rst_d4", link.digit_code[24:20], 5'd13);
      link.oe  = 1'b1;
      exp_disp = 1'b0;
      repeat (5) @(negedge clk);
      check("disp_off", link.disp_on, 1'b0);
      send_word({8'h46, 6'b000010});
      check("oe_high_decode", link.digit_code[9:5], 5'd12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
